bcd_counter_ndigit: RTL and testbench
=====================================

Name: bcd_counter_ndigit

Overview:
Parametrised multi-digit BCD up/down counter, the next generation of the team's single-digit BCD counter. It adds:
- N cascaded decimal digits
- count enable and direction control
- parallel load with BCD validity checking
- selectable wrap or saturate at the range ends
- terminal-count and error flags

It sits in timekeeping/display datapaths (e.g. seconds/minutes counters feeding 7-segment drivers) and is clocked from the system clock with a qualified enable, not a derived clock.

Parameters:
DIGITS, 4, number of BCD digits; legal range 1..8; count range 0 .. 10^DIGITS-1.
SATURATE, 0, 0 = wrap at range ends; 1 = hold at range ends.

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
enable  input  1  count qualifier; a count step happens only on cycles with enable=1
up_down  input  1  1 = increment, 0 = decrement; sampled on the same edge as enable
load  input  1  parallel-load strobe; takes priority over counting
load_value  input  4*DIGITS  load data; digit k is bits [4k+3:4k]; digit 0 is least significant
dout  output  4*DIGITS  registered count value in packed BCD
tc  output  1  registered one-cycle pulse on the cycle after a range-end crossing (wrap) or a blocked step (saturate)
at_limit  output  1  combinational from dout; 1 when dout is all-9s (up_down=1) or all-0s (up_down=0)
load_err  output  1  registered one-cycle pulse; a load contained at least one digit > 9

Behaviour:
- Reset: synchronous, active-high, highest priority. On reset dout=0, tc=0, load_err=0. Reset mid-count or coincident with load discards the load.
- Priority per edge: reset > load > (enable step) > hold.
- Load:
  - dout takes load_value on the next edge, one-cycle latency.
  - Any digit with value 10..15 is forced to 0 and load_err=1 for one cycle; valid digits load unchanged.
  - tc=0 on a load cycle.
- Hold: with enable=0 and load=0, dout, tc=0 and load_err=0 are held or cleared as appropriate; no state change.
- Increment (enable=1, up_down=1):
  - Digit 0 increments.
  - Digit k increments only if all lower digits are 9, and then those lower digits roll 9 -> 0.
  - Digit values never leave 0..9.
- Decrement is symmetric: digit k decrements only if all lower digits are 0, and those digits roll 0 -> 9.
- Range end, wrap mode (SATURATE=0):
  - All-9s +1 -> all-0s, tc=1 for one cycle.
  - All-0s -1 -> all-9s, tc=1 for one cycle.
- Range end, saturate mode (SATURATE=1):
  - All-9s +1 and all-0s -1 leave dout unchanged, tc=1.
  - tc repeats every cycle the blocked step is requested.
- Direction changes take effect on any cycle with no dead cycle; each edge uses the current up_down.
- Carry/borrow is computed in one clock (ripple within the cycle, no pipelining). A step latency of 1 cycle is required.
- Illegal internal digit state (>9, unreachable after reset) recovers to 0 on the next enabled step.
- No initial blocks for functionality; the reset value is authoritative.

Decomposition:
Shared package bcd_pkg holds:
- BCD_W=4
- BCD_MAX=4'd9, BCD_MIN=4'd0
- function is_valid_bcd(digit)

Natural sub-module bcd_digit_cell, one digit: ports clock, reset, inc_in, dec_in, load, load_digit, digit, carry_out (digit==9 & inc_in), borrow_out (digit==0 & dec_in), err.
- The top generates DIGITS instances, chains carry/borrow, and ORs the err outputs.
- The top owns the saturate gating, tc and load_err registers.

Test Plan:
1. Reset then 12 enabled up steps, DIGITS=2 -> dout sequence 00,01,...,09,10,11,12; tc never asserted; each digit stays in 0..9.
2. DIGITS=4, SATURATE=0: load 9998, then up x3 -> 9999, 0000 (tc=1 that cycle only), 0001.
3. DIGITS=4, SATURATE=0: load 0001, then down x3 -> 0000, 9999 (tc=1), 9998. Then load 1000, down x1 -> 0999 (multi-digit borrow).
4. SATURATE=1: at 9999 hold up_down=1, enable=1 for 3 cycles -> dout stays 9999, tc=1 on all 3 cycles; switch to down -> 9998, tc=0.
5. Load 0x3A7F -> dout=3070, load_err=1 for exactly one cycle. Load with enable=1 on the same cycle -> load wins and no step occurs.
6. Assert reset while enable=1 and load=1 with load_value=5555 -> dout=0000, tc=0, load_err=0 next edge. Toggle enable low mid-sequence -> value held.

Source files
------------

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD digit width, limits and validity helper.
package bcd_pkg;
  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
  localparam logic [BCD_W-1:0] BCD_MIN = 4'd0;
  function automatic logic is_valid_bcd(input logic [BCD_W-1:0] d);
    return d <= BCD_MAX;
  endfunction
endpackage

// File: rtl/bcd_counter_ndigit_digit_cell.sv
// bcd_digit_cell: one BCD digit with load, increment/decrement and carry/borrow out.
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             inc_in,
  input  logic             dec_in,
  input  logic             load,
  input  logic [BCD_W-1:0] load_digit,
  output logic [BCD_W-1:0] digit,
  output logic             carry_out,
  output logic             borrow_out,
  output logic             err
);
  logic [BCD_W-1:0] inc_val, dec_val;
  // Out-of-range digits fall back to 0 on any step.
  always_comb begin
    inc_val = (digit >= BCD_MAX) ? BCD_MIN : digit + 4'd1;
    dec_val = (digit == BCD_MIN) ? BCD_MAX : (digit > BCD_MAX) ? BCD_MIN : digit - 4'd1;
  end
  assign carry_out  = inc_in & (digit == BCD_MAX);
  assign borrow_out = dec_in & (digit == BCD_MIN);
  assign err        = load & !is_valid_bcd(load_digit);
  always_ff @(posedge clock) begin
    if (reset) digit <= BCD_MIN;
    else if (load) digit <= is_valid_bcd(load_digit) ? load_digit : BCD_MIN;
    else if (inc_in) digit <= inc_val;
    else if (dec_in) digit <= dec_val;
  end
endmodule

// File: rtl/bcd_counter_ndigit.sv
// bcd_counter_ndigit: N-digit BCD up/down counter with load, wrap/saturate and flags.
module bcd_counter_ndigit
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    up_down,
  input  logic                    load,
  input  logic [BCD_W*DIGITS-1:0] load_value,
  output logic [BCD_W*DIGITS-1:0] dout,
  output logic                    tc,
  output logic                    at_limit,
  output logic                    load_err
);
  logic [DIGITS:0]   inc, dec;
  logic [DIGITS-1:0] errs;
  logic all9, all0, step, block, tc_d;
  always_comb begin
    all9 = 1'b1;
    all0 = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      all9 &= dout[BCD_W*i +: BCD_W] == BCD_MAX;
      all0 &= dout[BCD_W*i +: BCD_W] == BCD_MIN;
    end
    at_limit = up_down ? all9 : all0;
    step     = enable & !load;
    block    = SATURATE & at_limit;
    inc[0]   = step & up_down & !block;
    dec[0]   = step & !up_down & !block;
    // Wrap mode flags the carry/borrow leaving the top digit; saturate flags the blocked step.
    tc_d     = SATURATE ? step & at_limit : inc[DIGITS] | dec[DIGITS];
  end
  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_digit_cell u_cell (
      .clock      (clock),
      .reset      (reset),
      .inc_in     (inc[k]),
      .dec_in     (dec[k]),
      .load       (load),
      .load_digit (load_value[BCD_W*k +: BCD_W]),
      .digit      (dout[BCD_W*k +: BCD_W]),
      .carry_out  (inc[k+1]),
      .borrow_out (dec[k+1]),
      .err        (errs[k])
    );
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      tc       <= 1'b0;
      load_err <= 1'b0;
    end else begin
      tc       <= tc_d;
      load_err <= |errs;
    end
  end
endmodule

// File: tb/tb_bcd_counter_ndigit.sv
// tb_bcd_counter_ndigit: directed checks on 4-digit wrap, 2-digit wrap and 4-digit saturate counters.
module tb_bcd_counter_ndigit;
  logic clock = 1'b0, reset, enable, up_down, load;
  logic [15:0] load_value;
  logic [15:0] dout, dout_s;
  logic [7:0]  dout2;
  logic tc, at_limit, load_err, tc2, at_limit2, load_err2, tc_s, at_limit_s, load_err_s;
  int checks = 0, failures = 0;

  always #5 clock = ~clock;

  bcd_counter_ndigit #(.DIGITS(4), .SATURATE(1'b0)) dut (
    .clock(clock), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
    .load_value(load_value), .dout(dout), .tc(tc), .at_limit(at_limit), .load_err(load_err));
  bcd_counter_ndigit #(.DIGITS(2), .SATURATE(1'b0)) dut2 (
    .clock(clock), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
    .load_value(load_value[7:0]), .dout(dout2), .tc(tc2), .at_limit(at_limit2), .load_err(load_err2));
  bcd_counter_ndigit #(.DIGITS(4), .SATURATE(1'b1)) dut_s (
    .clock(clock), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
    .load_value(load_value), .dout(dout_s), .tc(tc_s), .at_limit(at_limit_s), .load_err(load_err_s));

  task automatic cyc(input logic r, input logic l, input logic [15:0] lv, input logic e, input logic ud);
    reset = r; load = l; load_value = lv; enable = e; up_down = ud;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    cyc(1, 1, 16'h5555, 1, 1);
    checks++;
    if (dout !== 16'h0000 || tc !== 1'b0 || load_err !== 1'b0) begin
      failures++;
      $display("FAIL reset: dout=%h tc=%b load_err=%b, want 0000 0 0", dout, tc, load_err);
    end
  endtask

  task automatic test_count_up_2digit;
    logic [7:0] exp;
    cyc(1, 0, 16'h0, 0, 1);
    for (int i = 1; i <= 12; i++) begin
      cyc(0, 0, 16'h0, 1, 1);
      exp = 8'((i / 10) * 16 + (i % 10));
      checks++;
      if (dout2 !== exp || tc2 !== 1'b0) begin
        failures++;
        $display("FAIL up2 step %0d: dout=%h tc=%b, want %h 0", i, dout2, tc2, exp);
      end
    end
  endtask

  task automatic test_wrap_up;
    logic [15:0] exp_d [3] = '{16'h9999, 16'h0000, 16'h0001};
    logic        exp_t [3] = '{1'b0, 1'b1, 1'b0};
    cyc(0, 1, 16'h9998, 0, 1);
    checks++;
    if (dout !== 16'h9998 || tc !== 1'b0 || load_err !== 1'b0) begin
      failures++;
      $display("FAIL load9998: dout=%h tc=%b err=%b, want 9998 0 0", dout, tc, load_err);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 16'h0, 1, 1);
      checks++;
      if (dout !== exp_d[i] || tc !== exp_t[i]) begin
        failures++;
        $display("FAIL wrap_up %0d: dout=%h tc=%b, want %h %b", i, dout, tc, exp_d[i], exp_t[i]);
      end
    end
  endtask

  task automatic test_wrap_down;
    logic [15:0] exp_d [3] = '{16'h0000, 16'h9999, 16'h9998};
    logic        exp_t [3] = '{1'b0, 1'b1, 1'b0};
    cyc(0, 1, 16'h0001, 0, 0);
    checks++;
    if (at_limit !== 1'b0) begin
      failures++;
      $display("FAIL at_limit_0001: got %b want 0", at_limit);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 16'h0, 1, 0);
      checks++;
      if (dout !== exp_d[i] || tc !== exp_t[i]) begin
        failures++;
        $display("FAIL wrap_down %0d: dout=%h tc=%b, want %h %b", i, dout, tc, exp_d[i], exp_t[i]);
      end
    end
    cyc(0, 1, 16'h1000, 0, 0);
    cyc(0, 0, 16'h0, 1, 0);
    checks++;
    if (dout !== 16'h0999 || tc !== 1'b0) begin
      failures++;
      $display("FAIL borrow_chain: dout=%h tc=%b, want 0999 0", dout, tc);
    end
  endtask

  task automatic test_saturate;
    cyc(0, 1, 16'h9999, 0, 1);
    checks++;
    if (at_limit_s !== 1'b1 || at_limit !== 1'b1) begin
      failures++;
      $display("FAIL at_limit_9999: sat=%b wrap=%b want 1 1", at_limit_s, at_limit);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 16'h0, 1, 1);
      checks++;
      if (dout_s !== 16'h9999 || tc_s !== 1'b1) begin
        failures++;
        $display("FAIL sat_hold %0d: dout=%h tc=%b, want 9999 1", i, dout_s, tc_s);
      end
    end
    cyc(0, 0, 16'h0, 1, 0);
    checks++;
    if (dout_s !== 16'h9998 || tc_s !== 1'b0) begin
      failures++;
      $display("FAIL sat_down: dout=%h tc=%b, want 9998 0", dout_s, tc_s);
    end
    cyc(0, 1, 16'h0000, 0, 0);
    cyc(0, 0, 16'h0, 1, 0);
    checks++;
    if (dout_s !== 16'h0000 || tc_s !== 1'b1) begin
      failures++;
      $display("FAIL sat_floor: dout=%h tc=%b, want 0000 1", dout_s, tc_s);
    end
  endtask

  task automatic test_load_err;
    cyc(0, 1, 16'h3A7F, 0, 1);
    checks++;
    if (dout !== 16'h3070 || load_err !== 1'b1 || tc !== 1'b0) begin
      failures++;
      $display("FAIL load_bad: dout=%h err=%b tc=%b, want 3070 1 0", dout, load_err, tc);
    end
    cyc(0, 0, 16'h0, 0, 1);
    checks++;
    if (dout !== 16'h3070 || load_err !== 1'b0) begin
      failures++;
      $display("FAIL load_err_pulse: dout=%h err=%b, want 3070 0", dout, load_err);
    end
    cyc(0, 1, 16'h1234, 1, 1);
    checks++;
    if (dout !== 16'h1234 || load_err !== 1'b0 || tc !== 1'b0) begin
      failures++;
      $display("FAIL load_priority: dout=%h err=%b tc=%b, want 1234 0 0", dout, load_err, tc);
    end
  endtask

  task automatic test_reset_and_hold;
    cyc(0, 1, 16'h4321, 0, 1);
    cyc(1, 1, 16'h5555, 1, 1);
    checks++;
    if (dout !== 16'h0000 || tc !== 1'b0 || load_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: dout=%h tc=%b err=%b, want 0000 0 0", dout, tc, load_err);
    end
    cyc(0, 0, 16'h0, 1, 1);
    cyc(0, 0, 16'h0, 0, 1);
    checks++;
    if (dout !== 16'h0001) begin
      failures++;
      $display("FAIL hold: dout=%h, want 0001", dout);
    end
    cyc(0, 0, 16'h0, 1, 1);
    checks++;
    if (dout !== 16'h0002) begin
      failures++;
      $display("FAIL resume: dout=%h, want 0002", dout);
    end
    cyc(0, 0, 16'h0, 1, 0);
    checks++;
    if (dout !== 16'h0001 || tc !== 1'b0) begin
      failures++;
      $display("FAIL dir_change: dout=%h tc=%b, want 0001 0", dout, tc);
    end
  endtask

  initial begin
    test_reset;
    test_count_up_2digit;
    test_wrap_up;
    test_wrap_down;
    test_saturate;
    test_load_err;
    test_reset_and_hold;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
